// File: rtl/operand_entry_fsm.sv
// Keypad front end: turns debounced key strobes into two sign-magnitude operands
// and an add/sub select, presented to the adder stage with a valid/ack handshake.
module operand_entry_fsm #(
   parameter int unsigned MAG_W      = 8,
   parameter int unsigned DIGITS_MAX = 3
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Key_Valid,
   input  logic [3:0]       Key_Code,
   input  logic             Op_Ack,
   output logic [MAG_W-1:0] A,
   output logic [MAG_W-1:0] B,
   output logic             Sign_A,
   output logic             Sign_B,
   output logic             Op,
   output logic             Op_Valid,
   output logic             Key_Err
);

   localparam int unsigned ACC_W   = MAG_W + 4;
   localparam int unsigned CNT_W   = $clog2(DIGITS_MAX + 1);
   localparam int unsigned MAG_MAX = (2 ** MAG_W) - 1;

   localparam logic [3:0] K_PLUS  = 4'hA;
   localparam logic [3:0] K_MINUS = 4'hB;
   localparam logic [3:0] K_SIGN  = 4'hC;
   localparam logic [3:0] K_CE    = 4'hD;
   localparam logic [3:0] K_EQ    = 4'hE;
   localparam logic [3:0] K_AC    = 4'hF;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [MAG_W-1:0]   a_q, a_d, b_q, b_d;
   logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic               op_q, op_d, op_valid_q, op_valid_d, key_err_q, key_err_d;
   logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

   logic               is_digit_c;
   logic [MAG_W-1:0]   cur_mag_c;
   logic [CNT_W-1:0]   cur_cnt_c;
   logic [ACC_W-1:0]   acc_c;
   logic               digit_ok_c;

   // Shared digit accumulator for whichever operand is being entered
   always_comb begin
      is_digit_c = (Key_Code <= 4'd9);
      cur_mag_c  = (state_q == S_B) ? b_q : a_q;
      cur_cnt_c  = (state_q == S_B) ? cnt_b_q : cnt_a_q;
      acc_c      = ACC_W'(cur_mag_c) * ACC_W'(10) + ACC_W'(Key_Code);
      digit_ok_c = (cur_cnt_c < CNT_W'(DIGITS_MAX)) && (acc_c <= ACC_W'(MAG_MAX));
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      op_d       = op_q;
      op_valid_d = op_valid_q;
      key_err_d  = 1'b0;
      cnt_a_d    = cnt_a_q;
      cnt_b_d    = cnt_b_q;

      if (Key_Valid && (Key_Code == K_AC)) begin
         state_d    = S_A;
         a_d        = '0;
         b_d        = '0;
         sign_a_d   = 1'b0;
         sign_b_d   = 1'b0;
         op_d       = 1'b0;
         op_valid_d = 1'b0;
         cnt_a_d    = '0;
         cnt_b_d    = '0;
      end else begin
         unique case (state_q)
            S_A: begin
               if (Key_Valid) begin
                  if (is_digit_c) begin
                     if (digit_ok_c) begin
                        a_d     = MAG_W'(acc_c);
                        cnt_a_d = cnt_a_q + CNT_W'(1);
                     end else begin
                        key_err_d = 1'b1;
                     end
                  end else if (Key_Code == K_SIGN) begin
                     sign_a_d = ~sign_a_q;
                  end else if (Key_Code == K_CE) begin
                     a_d      = '0;
                     sign_a_d = 1'b0;
                     cnt_a_d  = '0;
                  end else if ((Key_Code == K_PLUS) || (Key_Code == K_MINUS)) begin
                     op_d     = (Key_Code == K_MINUS);
                     b_d      = '0;
                     sign_b_d = 1'b0;
                     cnt_b_d  = '0;
                     state_d  = S_B;
                  end else begin
                     key_err_d = 1'b1;
                  end
               end
            end
            S_B: begin
               if (Key_Valid) begin
                  if (is_digit_c) begin
                     if (digit_ok_c) begin
                        b_d     = MAG_W'(acc_c);
                        cnt_b_d = cnt_b_q + CNT_W'(1);
                     end else begin
                        key_err_d = 1'b1;
                     end
                  end else if (Key_Code == K_SIGN) begin
                     sign_b_d = ~sign_b_q;
                  end else if (Key_Code == K_CE) begin
                     b_d      = '0;
                     sign_b_d = 1'b0;
                     cnt_b_d  = '0;
                  end else if ((Key_Code == K_PLUS) || (Key_Code == K_MINUS)) begin
                     // Operator may only be changed before any B digit is typed
                     if (cnt_b_q == '0) begin
                        op_d = (Key_Code == K_MINUS);
                     end else begin
                        key_err_d = 1'b1;
                     end
                  end else if (Key_Code == K_EQ) begin
                     if (a_q == '0) sign_a_d = 1'b0;
                     if (b_q == '0) sign_b_d = 1'b0;
                     op_valid_d = 1'b1;
                     state_d    = S_DONE;
                  end else begin
                     key_err_d = 1'b1;
                  end
               end
            end
            S_DONE: begin
               // Ack wins over a simultaneous key, which is dropped silently
               if (Op_Ack) begin
                  state_d    = S_A;
                  a_d        = '0;
                  b_d        = '0;
                  sign_a_d   = 1'b0;
                  sign_b_d   = 1'b0;
                  op_d       = 1'b0;
                  op_valid_d = 1'b0;
                  cnt_a_d    = '0;
                  cnt_b_d    = '0;
               end else if (Key_Valid) begin
                  key_err_d = 1'b1;
               end
            end
            default: begin
               state_d = S_A;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= S_A;
         a_q        <= '0;
         b_q        <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         op_q       <= 1'b0;
         op_valid_q <= 1'b0;
         key_err_q  <= 1'b0;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         op_q       <= op_d;
         op_valid_q <= op_valid_d;
         key_err_q  <= key_err_d;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
      end
   end

   assign A        = a_q;
   assign B        = b_q;
   assign Sign_A   = sign_a_q;
   assign Sign_B   = sign_b_q;
   assign Op       = op_q;
   assign Op_Valid = op_valid_q;
   assign Key_Err  = key_err_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed self-checking bench for operand_entry_fsm; inputs change and outputs
// are sampled on the falling clock edge.
module tb_operand_entry_fsm;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       Key_Valid;
   logic [3:0] Key_Code;
   logic       Op_Ack;
   logic [7:0] A, B;
   logic       Sign_A, Sign_B, Op, Op_Valid, Key_Err;

   int n_tests = 0;
   int n_fail  = 0;

   operand_entry_fsm #(.MAG_W(8), .DIGITS_MAX(3)) dut (
      .Clk(Clk), .Rst(Rst), .Key_Valid(Key_Valid), .Key_Code(Key_Code),
      .Op_Ack(Op_Ack), .A(A), .B(B), .Sign_A(Sign_A), .Sign_B(Sign_B),
      .Op(Op), .Op_Valid(Op_Valid), .Key_Err(Key_Err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge, after the key is sampled
   task automatic press(input logic [3:0] code);
      Key_Valid = 1'b1;
      Key_Code  = code;
      @(negedge Clk);
      Key_Valid = 1'b0;
      Key_Code  = 4'h0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".A"}, 32'(A), 0);
      check({tag, ".B"}, 32'(B), 0);
      check({tag, ".sa"}, 32'(Sign_A), 0);
      check({tag, ".sb"}, 32'(Sign_B), 0);
      check({tag, ".op"}, 32'(Op), 0);
      check({tag, ".ov"}, 32'(Op_Valid), 0);
   endtask

   initial begin
      Rst = 1'b0; Key_Valid = 1'b0; Key_Code = 4'h0; Op_Ack = 1'b0;
      repeat (2) @(negedge Clk);
      check_all_zero("rst");
      check("rst.err", 32'(Key_Err), 0);
      Rst = 1'b1;
      @(negedge Clk);

      // 1: 1,2,3 -> 123, no errors, still entering A ('=' rejected)
      press(4'd1); check("t1.err1", 32'(Key_Err), 0);
      press(4'd2); check("t1.err2", 32'(Key_Err), 0);
      press(4'd3); check("t1.err3", 32'(Key_Err), 0);
      check("t1.A", 32'(A), 123);
      check("t1.sa", 32'(Sign_A), 0);
      press(4'hE); check("t1.eq_in_A_err", 32'(Key_Err), 1);
      check("t1.A_hold", 32'(A), 123);
      Op_Ack = 1'b1; @(negedge Clk); Op_Ack = 1'b0;
      check("t1.ack_ignored", 32'(A), 123);
      press(4'hD); check("t1.ce", 32'(A), 0);
      press(4'hF);

      // 2: overflow and digit-count limits
      press(4'd2); press(4'd5);
      press(4'd6); check("t2.ovf_err", 32'(Key_Err), 1);
      check("t2.A25", 32'(A), 25);
      @(negedge Clk); check("t2.err_pulse", 32'(Key_Err), 0);
      press(4'hF);
      press(4'd1); press(4'd0); press(4'd0);
      check("t2.A100", 32'(A), 100);
      press(4'd0); check("t2.cnt_err", 32'(Key_Err), 1);
      check("t2.A100b", 32'(A), 100);
      press(4'hF);

      // 3: 1,2,C,-,4,5,= with operand hold and ack
      press(4'd1); press(4'd2); press(4'hC); press(4'hB); press(4'd4); press(4'd5);
      check("t3.ov_pre", 32'(Op_Valid), 0);
      press(4'hE);
      check("t3.A", 32'(A), 12);
      check("t3.sa", 32'(Sign_A), 1);
      check("t3.op", 32'(Op), 1);
      check("t3.B", 32'(B), 45);
      check("t3.sb", 32'(Sign_B), 0);
      check("t3.ov", 32'(Op_Valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         check("t3.ov_hold", 32'(Op_Valid), 1);
         check("t3.B_hold", 32'(B), 45);
      end
      Op_Ack = 1'b1; @(negedge Clk); Op_Ack = 1'b0;
      check_all_zero("t3.ack");

      // 4: negative zero suppressed
      press(4'hC); check("t4.sa_tog", 32'(Sign_A), 1);
      press(4'hA); press(4'hC); check("t4.sb_tog", 32'(Sign_B), 1);
      press(4'hE);
      check("t4.sa", 32'(Sign_A), 0);
      check("t4.sb", 32'(Sign_B), 0);
      check("t4.A", 32'(A), 0);
      check("t4.B", 32'(B), 0);
      check("t4.op", 32'(Op), 0);
      check("t4.ov", 32'(Op_Valid), 1);
      Op_Ack = 1'b1; @(negedge Clk); Op_Ack = 1'b0;

      // Operator replacement only before B digits
      press(4'd4); press(4'hA); press(4'hB);
      check("t4b.op_replace", 32'(Op), 1);
      check("t4b.no_err", 32'(Key_Err), 0);
      press(4'd6); press(4'hA);
      check("t4b.op_locked_err", 32'(Key_Err), 1);
      check("t4b.op_kept", 32'(Op), 1);
      press(4'hF);

      // 5: asynchronous reset mid-entry
      press(4'd9); press(4'hA); press(4'd7);
      check("t5.A", 32'(A), 9);
      check("t5.B", 32'(B), 7);
      #2 Rst = 1'b0;
      #1 check_all_zero("t5.async");
      @(negedge Clk); Rst = 1'b1;
      @(negedge Clk);
      press(4'd3); check("t5.A3", 32'(A), 3);
      check("t5.ov", 32'(Op_Valid), 0);
      press(4'hF);

      // 6: keys while operands are presented
      press(4'd1); press(4'hA); press(4'd2); press(4'hE);
      press(4'd5); check("t6.key_err", 32'(Key_Err), 1);
      check("t6.A", 32'(A), 1);
      check("t6.B", 32'(B), 2);
      check("t6.ov", 32'(Op_Valid), 1);
      press(4'hF); check("t6.ac_err", 32'(Key_Err), 0);
      check_all_zero("t6.ac");
      press(4'd1); press(4'hA); press(4'd2); press(4'hE);
      Op_Ack = 1'b1;
      press(4'd5);
      Op_Ack = 1'b0;
      check("t6.ack_key_err", 32'(Key_Err), 0);
      check_all_zero("t6.ack_key");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
